// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encodings and SRAM status codes for the port arbiter
package sram_arb_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 3'd0;
    localparam arb_state_t ST_LO_ISSUE = 3'd1;
    localparam arb_state_t ST_LO_WAIT  = 3'd2;
    localparam arb_state_t ST_HI_ISSUE = 3'd3;
    localparam arb_state_t ST_HI_WAIT  = 3'd4;
    localparam arb_state_t ST_FINISH   = 3'd5;

    // 2'b10 is reserved by the wrapper and is handled like BUSY
    localparam logic [1:0] SRAM_FREE  = 2'b00;
    localparam logic [1:0] SRAM_BUSY  = 2'b01;
    localparam logic [1:0] SRAM_ERROR = 2'b11;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// rtl/sram_port_arbiter_rr_picker.sv - combinational round-robin winner select starting after ptr
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NREQ);
            if (!valid && req[cand]) begin
                winner[cand] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter splitting 64-bit requests into two 32-bit SRAM accesses
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int IDX_W   = 9,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*IDX_W-1:0] req_idx,
    input  logic [NREQ*64-1:0]    req_wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       err,
    output logic [63:0]           rdata,
    output logic                  busy,
    output logic [IDX_W:0]        addr,
    output logic                  ren,
    output logic                  wen,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata_sram,
    input  logic [1:0]            sram_state
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    logic [NREQ-1:0]  pick_onehot;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic [NREQ-1:0]  win_q;

    logic             sel_write;
    logic [IDX_W-1:0] sel_idx;
    logic [63:0]      sel_wdata;
    logic             lat_write;
    logic [IDX_W-1:0] lat_idx;
    logic [63:0]      lat_wdata;

    logic             half_q;
    logic             abort_q;
    logic             busy_seen;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      shadow_lo;
    logic [63:0]      rdata_q;
    logic             in_issue;
    logic             in_wait;
    logic             wait_ok;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx  = '0;
        sel_write = 1'b0;
        sel_idx   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx  = PTR_W'(i);
                sel_write = req_write[i];
                sel_idx   = req_idx[i*IDX_W +: IDX_W];
                sel_wdata = req_wdata[i*64 +: 64];
            end
        end
    end

    assign in_issue = (state == ST_LO_ISSUE) || (state == ST_HI_ISSUE);
    assign in_wait  = (state == ST_LO_WAIT)  || (state == ST_HI_WAIT);
    // completion needs a BUSY first so a stale FREE right after issue is not mistaken for the response
    assign wait_ok  = busy_seen && (sram_state == SRAM_FREE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            win_q     <= '0;
            rr_ptr    <= PTR_W'(NREQ - 1);
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            half_q    <= HALF_LO;
            abort_q   <= 1'b0;
            busy_seen <= 1'b0;
            cnt       <= '0;
            shadow_lo <= '0;
            rdata_q   <= '0;
        end else begin
            if (in_issue || in_wait) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (in_wait && (sram_state != SRAM_FREE)) begin
                busy_seen <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_LO_ISSUE;
                        win_q     <= pick_onehot;
                        rr_ptr    <= pick_idx;
                        lat_write <= sel_write;
                        lat_idx   <= sel_idx;
                        lat_wdata <= sel_wdata;
                        half_q    <= HALF_LO;
                        abort_q   <= 1'b0;
                        cnt       <= '0;
                        busy_seen <= 1'b0;
                    end
                end
                ST_LO_ISSUE: state <= ST_LO_WAIT;
                ST_HI_ISSUE: state <= ST_HI_WAIT;
                ST_LO_WAIT, ST_HI_WAIT: begin
                    if (sram_state == SRAM_ERROR) begin
                        abort_q <= 1'b1;
                        state   <= ST_FINISH;
                    end else if (wait_ok) begin
                        if (half_q == HALF_LO) begin
                            if (!lat_write) begin
                                shadow_lo <= rdata_sram;
                            end
                            half_q    <= HALF_HI;
                            cnt       <= '0;
                            busy_seen <= 1'b0;
                            state     <= ST_HI_ISSUE;
                        end else begin
                            // rdata must already be valid in the cycle done pulses
                            if (!lat_write) begin
                                rdata_q <= {rdata_sram, shadow_lo};
                            end
                            state <= ST_FINISH;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        abort_q <= 1'b1;
                        state   <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign gnt   = (state == ST_LO_ISSUE) ? win_q : '0;
    assign done  = ((state == ST_FINISH) && !abort_q) ? win_q : '0;
    assign err   = ((state == ST_FINISH) && abort_q) ? win_q : '0;
    assign ren   = in_issue && !lat_write;
    assign wen   = in_issue && lat_write;
    assign addr  = {lat_idx, half_q};
    assign wdata = (half_q == HALF_HI) ? lat_wdata[63:32] : lat_wdata[31:0];
    assign busy  = (state != ST_IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter with a behavioural SRAM wrapper
module tb_sram_port_arbiter;

    localparam int NREQ    = 3;
    localparam int IDX_W   = 9;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*IDX_W-1:0] req_idx;
    logic [NREQ*64-1:0]    req_wdata;
    logic [NREQ-1:0]       gnt, done, err;
    logic [63:0]           rdata;
    logic                  busy, ren, wen;
    logic [IDX_W:0]        addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata_sram;
    logic [1:0]            sram_state;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .NREQ    (NREQ),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req        (req),
        .req_write  (req_write),
        .req_idx    (req_idx),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .addr       (addr),
        .ren        (ren),
        .wen        (wen),
        .wdata      (wdata),
        .rdata_sram (rdata_sram),
        .sram_state (sram_state)
    );

    typedef struct {
        int          who;
        bit          is_err;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [42:0] acc_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    int          busy_len = 1;
    bit          hang_hi = 1'b0;
    bit          err_lo = 1'b0;
    logic [31:0] mem [0:1023];
    bit          wr_flag [0:1023];
    int          bcnt;
    logic        cur_odd;

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // behavioural wrapper: BUSY for busy_len cycles after each access, optional hang/error injection
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sram_state <= 2'b00;
            rdata_sram <= '0;
            bcnt       <= 0;
            cur_odd    <= 1'b0;
        end else if (ren || wen) begin
            if (wen) begin
                mem[addr]     <= wdata;
                wr_flag[addr] <= 1'b1;
            end
            rdata_sram <= wr_flag[addr] ? mem[addr] : init_val(addr);
            sram_state <= (err_lo && !addr[0]) ? 2'b11 : 2'b01;
            bcnt       <= busy_len;
            cur_odd    <= addr[0];
        end else if (sram_state != 2'b00) begin
            if (sram_state == 2'b11) begin
                sram_state <= 2'b11;
            end else if (hang_hi && cur_odd) begin
                sram_state <= sram_state;
            end else if (bcnt <= 1) begin
                sram_state <= 2'b00;
            end else begin
                bcnt <= bcnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (n_rst && (ren || wen)) acc_q.push_back({wen, addr, wdata});
    end

    task automatic set_req(input int i, input bit wr, input logic [IDX_W-1:0] idx, input logic [63:0] d);
        req_write[i]              = wr;
        req_idx[i*IDX_W +: IDX_W] = idx;
        req_wdata[i*64 +: 64]     = d;
        req[i]                    = 1'b1;
    endtask

    task automatic wait_end(input int limit, output logic [NREQ-1:0] d, output logic [NREQ-1:0] e,
                            output int cyc);
        d   = '0;
        e   = '0;
        cyc = 0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            req = req & ~gnt;
            if (|done || |err) begin
                d = done;
                e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        req = '0; req_write = '0; req_idx = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({gnt, done, err, ren, wen, busy, addr, wdata, rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%b done=%b err=%b ren=%b wen=%b busy=%b addr=%h wdata=%h rdata=%h want all 0",
                     gnt, done, err, ren, wen, busy, addr, wdata, rdata);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || gnt !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b gnt=%b want 0 0", busy, gnt);
        end
    endtask

    task automatic test_write_read();
        exp_t ex;
        logic [NREQ-1:0] d, e;
        int cyc;
        @(negedge clk);
        busy_len = 3;
        acc_q.delete();
        sb_q.push_back('{who: 0, is_err: 1'b0, rdata: 64'd0});
        set_req(0, 1'b1, 9'd5, 64'hAAAA0005_BBBB0005);
        wait_end(200, d, e, cyc);
        ex = sb_q.pop_front();
        vectors++;
        if (d !== NREQ'(1 << ex.who) || e !== '0) begin
            miscompares++;
            $display("FAIL wr_done: done=%b err=%b want done=%b err=0", d, e, NREQ'(1 << ex.who));
        end
        vectors++;
        if (acc_q.size() != 2 || acc_q[0] !== {1'b1, 10'd10, 32'hBBBB0005} || acc_q[1] !== {1'b1, 10'd11, 32'hAAAA0005}) begin
            miscompares++;
            $display("FAIL wr_access: n=%0d a0=%h a1=%h want 2 %h %h", acc_q.size(), acc_q[0], acc_q[1],
                     {1'b1, 10'd10, 32'hBBBB0005}, {1'b1, 10'd11, 32'hAAAA0005});
        end
        @(negedge clk);
        sb_q.push_back('{who: 1, is_err: 1'b0, rdata: 64'hAAAA0005_BBBB0005});
        set_req(1, 1'b0, 9'd5, 64'd0);
        wait_end(200, d, e, cyc);
        ex = sb_q.pop_front();
        vectors++;
        if (d !== NREQ'(1 << ex.who) || e !== '0 || rdata !== ex.rdata) begin
            miscompares++;
            $display("FAIL rd_done: done=%b err=%b rdata=%h want done=%b rdata=%h", d, e, rdata,
                     NREQ'(1 << ex.who), ex.rdata);
        end
    endtask

    task automatic test_latency();
        exp_t ex;
        logic [NREQ-1:0] d, e;
        int cyc;
        @(negedge clk);
        busy_len = 1;
        acc_q.delete();
        sb_q.push_back('{who: 2, is_err: 1'b0, rdata: {init_val(10'd15), init_val(10'd14)}});
        set_req(2, 1'b0, 9'd7, 64'd0);
        wait_end(50, d, e, cyc);
        ex = sb_q.pop_front();
        vectors++;
        if (d !== NREQ'(1 << ex.who) || rdata !== ex.rdata) begin
            miscompares++;
            $display("FAIL lat_done: done=%b rdata=%h want done=%b rdata=%h", d, rdata, NREQ'(1 << ex.who), ex.rdata);
        end
        vectors++;
        if (cyc != 7) begin
            miscompares++;
            $display("FAIL lat_cycles: done after %0d edges want 7", cyc);
        end
        vectors++;
        if (acc_q.size() != 2 || acc_q[0][42:32] !== {1'b0, 10'd14} || acc_q[1][42:32] !== {1'b0, 10'd15}) begin
            miscompares++;
            $display("FAIL lat_strobes: n=%0d a0=%h a1=%h want 2 reads at 14,15", acc_q.size(), acc_q[0], acc_q[1]);
        end
    endtask

    task automatic test_round_robin();
        exp_t ex;
        int order[$];
        int gcyc = 0, idle = 0, n = 0, cyc = 0, bad = 0;
        bit started = 1'b0, order_bad = 1'b0;
        @(negedge clk);
        busy_len = 1;
        for (int k = 0; k < 6; k++) begin
            ex.who    = k % 3;
            ex.is_err = 1'b0;
            ex.rdata  = {init_val(10'(2 * (20 + k % 3) + 1)), init_val(10'(2 * (20 + k % 3)))};
            sb_q.push_back(ex);
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 9'(20 + i), 64'd0);
        while (n < 6 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if ($countones({gnt, done, err}) > 1) bad++;
            if (|gnt) begin
                order.push_back(oh_idx(gnt));
                gcyc++;
                started = 1'b1;
            end
            if (started && !busy) idle++;
            if (|done || |err) begin
                ex = sb_q.pop_front();
                n++;
                vectors++;
                if (done !== NREQ'(1 << ex.who) || err !== '0 || rdata !== ex.rdata) begin
                    miscompares++;
                    $display("FAIL rr_txn%0d: done=%b err=%b rdata=%h want who=%0d rdata=%h", n, done, err,
                             rdata, ex.who, ex.rdata);
                end
                if (n == 6) req = '0;
            end
        end
        req = '0;
        sb_q.delete();
        if (order.size() != 6) order_bad = 1'b1;
        for (int k = 0; k < order.size(); k++) if (order[k] != k % 3) order_bad = 1'b1;
        vectors++;
        if (n != 6 || order_bad) begin
            miscompares++;
            $display("FAIL rr_order: %0d grants %p want 0,1,2,0,1,2", order.size(), order);
        end
        vectors++;
        if (gcyc != 6 || idle != 5) begin
            miscompares++;
            $display("FAIL rr_timing: gnt_cycles=%0d idle_cycles=%0d want 6 5", gcyc, idle);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rr_onehot: %0d cycles with several pulses want 0", bad);
        end
    endtask

    task automatic test_timeout();
        exp_t ex;
        logic [NREQ-1:0] d, e;
        int cyc = 0, hi_at = -1;
        @(negedge clk);
        busy_len = 1;
        hang_hi = 1'b1;
        sb_q.push_back('{who: 1, is_err: 1'b1, rdata: rdata});
        set_req(1, 1'b0, 9'd30, 64'd0);
        d = '0;
        e = '0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            req = req & ~gnt;
            if (ren && addr[0] && hi_at < 0) hi_at = cyc;
            if (|done || |err) begin
                d = done;
                e = err;
                break;
            end
        end
        ex = sb_q.pop_front();
        vectors++;
        if (e !== NREQ'(1 << ex.who) || d !== '0 || rdata !== ex.rdata) begin
            miscompares++;
            $display("FAIL to_err: err=%b done=%b rdata=%h want err=%b done=0 rdata=%h", e, d, rdata,
                     NREQ'(1 << ex.who), ex.rdata);
        end
        vectors++;
        if (hi_at < 0 || cyc - hi_at != TIMEOUT) begin
            miscompares++;
            $display("FAIL to_cycles: err %0d cycles after hi issue want %0d", cyc - hi_at, TIMEOUT);
        end
        hang_hi = 1'b0;
        @(negedge clk);
        sb_q.push_back('{who: 0, is_err: 1'b0, rdata: 64'd0});
        set_req(0, 1'b1, 9'd30, 64'h1234_5678_9ABC_DEF0);
        wait_end(100, d, e, cyc);
        ex = sb_q.pop_front();
        vectors++;
        if (d !== NREQ'(1 << ex.who) || e !== '0) begin
            miscompares++;
            $display("FAIL to_recover: done=%b err=%b want done=%b err=0", d, e, NREQ'(1 << ex.who));
        end
    endtask

    task automatic test_sram_error();
        exp_t ex;
        logic [NREQ-1:0] d, e;
        int cyc = 0;
        bit odd_seen = 1'b0;
        @(negedge clk);
        err_lo = 1'b1;
        acc_q.delete();
        sb_q.push_back('{who: 2, is_err: 1'b1, rdata: rdata});
        set_req(2, 1'b1, 9'd31, 64'h5555_6666_7777_8888);
        d = '0;
        e = '0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            req = req & ~gnt;
            if (busy && addr[0]) odd_seen = 1'b1;
            if (|done || |err) begin
                d = done;
                e = err;
                break;
            end
        end
        ex = sb_q.pop_front();
        vectors++;
        if (e !== NREQ'(1 << ex.who) || d !== '0) begin
            miscompares++;
            $display("FAIL serr_err: err=%b done=%b want err=%b done=0", e, d, NREQ'(1 << ex.who));
        end
        vectors++;
        if (odd_seen || acc_q.size() != 1) begin
            miscompares++;
            $display("FAIL serr_no_hi: odd_addr=%0b accesses=%0d want 0 1", odd_seen, acc_q.size());
        end
        err_lo = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        bit reached = 1'b0;
        @(negedge clk);
        hang_hi = 1'b1;
        set_req(1, 1'b0, 9'd40, 64'd0);
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            req = req & ~gnt;
            if (busy && addr[0] && !ren && !wen) begin
                reached = 1'b1;
                break;
            end
        end
        #2;
        n_rst = 1'b0;
        #1;
        vectors++;
        if (!reached || {gnt, done, err, ren, wen, busy, addr, wdata, rdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid: reached_hi_wait=%0b gnt=%b done=%b err=%b ren=%b wen=%b busy=%b addr=%h rdata=%h want 1 and all 0",
                     reached, gnt, done, err, ren, wen, busy, addr, rdata);
        end
        hang_hi = 1'b0;
        req = '0;
        set_req(2, 1'b0, 9'd41, 64'd0);
        set_req(0, 1'b0, 9'd42, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc = 0;
        while (cyc < 10 && gnt === '0) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (gnt !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_first_gnt: gnt=%b want 001", gnt);
        end
        req = '0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_round_robin();
        test_timeout();
        test_sram_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single sram1024x32_wrapper port between up to N requesters: host write path, weight/input fetch, and output writeback.
- Each requester issues 64-bit read or write transactions.
- The arbiter grants one requester at a time, round-robin, and serialises each transaction into two 32-bit SRAM accesses (low half, then high half).
- It follows the wrapper's sram_state handshake, with a timeout and error abort.

Parameters:
- NREQ, 3, number of requesters (2..4)
- IDX_W, 9, 64-bit word index width; SRAM address = {idx, half}, 10 bits
- TIMEOUT, 64, max cycles per 32-bit access before abort

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester transaction request, level
- req_write  in  NREQ  per-requester: 1 = write, 0 = read
- req_idx  in  NREQ*IDX_W  per-requester 64-bit word index, packed with requester 0 in the LSBs
- req_wdata  in  NREQ*64  per-requester write data, packed
- gnt  out  NREQ  one-hot pulse; the transaction has been accepted and latched
- done  out  NREQ  one-hot pulse; transaction complete (rdata valid on reads)
- err  out  NREQ  one-hot pulse, replaces done on timeout or SRAM error
- rdata  out  64  read result, held until the next read completes
- busy  out  1  high in any state other than IDLE
- addr  out  10  SRAM address
- ren  out  1  SRAM read enable
- wen  out  1  SRAM write enable
- wdata  out  32  SRAM write data
- rdata_sram  in  32  SRAM read data
- sram_state  in  2  wrapper status: 00 FREE, 01 BUSY, 10 reserved (treated as BUSY), 11 ERROR

Behaviour:
- Reset (async, n_rst=0): state IDLE; gnt, done, err, ren, wen, busy, addr, wdata, rdata all 0; rr_ptr = NREQ-1, so requester 0 wins first. Reset mid-transaction abandons it with no completion pulse, and the SRAM contents may hold a half-written word.
- States: IDLE, LO_ISSUE, LO_WAIT, HI_ISSUE, HI_WAIT, FINISH.
- IDLE, any req high at edge t: select the first requester with req=1 scanning cyclically from rr_ptr+1. At t+1 enter LO_ISSUE; latch write/idx/wdata of the winner; rr_ptr = winner.
- LO_ISSUE (1 cycle):
  - gnt[w]=1.
  - addr={idx,1'b0}; wdata=latched[31:0].
  - ren=!write, wen=write.
  - Next state LO_WAIT.
- LO_WAIT:
  - ren and wen are 0; addr and wdata are held.
  - busy_seen sets when sram_state != FREE.
  - When busy_seen and sram_state == FREE: on a read, capture rdata_sram into the low half of a shadow register; go to HI_ISSUE.
  - sram_state == ERROR, or the cycle counter reaching TIMEOUT: go to FINISH with the abort flag set.
- HI_ISSUE and HI_WAIT: identical to LO_ISSUE and LO_WAIT but with addr={idx,1'b1} and wdata=[63:32]. gnt is not re-pulsed.
- FINISH (1 cycle):
  - Normal completion: done[w]=1; on a read, rdata = shadow register.
  - Abort: err[w]=1 and rdata is unchanged.
  - Next state IDLE.
- Cycle counter and busy_seen clear on every ISSUE.
- Minimum latency, req to done: 6 cycles with a 1-cycle BUSY SRAM.
- Requester rules:
  - A requester holds req until it sees gnt, then may drop it.
  - req still high in IDLE after done is a new transaction.
  - req_idx/wdata changes after gnt are ignored.
- Simultaneous requests resolve by round-robin only; no starvation. Each requester is served within NREQ transactions.
- req deasserted before being granted: no effect.
- Only one of gnt, done, err is high per cycle; at most one bit of each.

Decomposition:
- Package sram_arb_pkg: state enum arb_state_t; sram_state codes SRAM_FREE, SRAM_BUSY, SRAM_ERROR; constant HALF_LO/HALF_HI.
- Sub-module rr_picker (NREQ-wide request vector plus pointer in, one-hot winner plus valid out, combinational) is natural; the rest is in the top.

Test Plan:
- Single write then read: req0 writes idx 5, data 64'hAAAA0005_BBBB0005; a behavioural SRAM model gives 3 cycles BUSY. Then req1 reads idx 5.
  - Write: SRAM sees addr 10 with wdata BBBB0005, then addr 11 with AAAA0005.
  - Read: done[1] pulses and rdata = AAAA0005_BBBB0005.
- Round-robin: all three requesters hold req continuously for 6 transactions → gnt order 0,1,2,0,1,2; each gnt one cycle; busy low for exactly 1 cycle between transactions.
- Latency: 1-cycle BUSY model → done exactly 6 cycles after the first req-high edge; ren/wen pulse exactly once per half.
- Timeout: the model holds BUSY forever on the high half → err[i] pulses at TIMEOUT cycles after HI_ISSUE, no done, rdata unchanged. The next request then completes normally.
- SRAM error: the model returns 11 during LO_WAIT → err pulses; no HI access is issued (addr never odd).
- Reset mid-operation: drop n_rst during HI_WAIT → all outputs 0 immediately. After release, req2 and req0 are both pending → req0 granted first.
